// File: rtl/leaf_stream_arbiter_if.sv
// Stream bundle between requesters, the arbiter and leaf_interface.
// master = arbiter view (drives acks and the merged output), slave = surrounding logic.
interface leaf_stream_arbiter_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int SRC_BITS     = 4
);
  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req;
  logic [NUM_REQ-1:0]              vld_req;
  logic [NUM_REQ-1:0]              ack_req;
  logic [PAYLOAD_BITS-1:0]         dout;
  logic                            vld_out;
  logic                            ack_out;
  logic [SRC_BITS-1:0]             src_out;

  modport master (
    input  din_req, vld_req, ack_out,
    output ack_req, dout, vld_out, src_out
  );

  modport slave (
    output din_req, vld_req, ack_out,
    input  ack_req, dout, vld_out, src_out
  );
endinterface

// File: rtl/leaf_stream_arbiter.sv
// Round-robin merge of NUM_REQ ap_vld/ap_ack streams onto one registered, source-tagged port.
// Optional burst lock (BURST_LEN beats per grant) is compiled in with ARB_BURST_LOCK_EN.
module leaf_stream_arbiter #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int SRC_BITS     = 4,
  parameter int BURST_LEN    = 8
) (
  input  logic                  clk_user,
  input  logic                  reset,
  leaf_stream_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || (1 << SRC_BITS) < NUM_REQ ||
      BURST_LEN < 1 || BURST_LEN > 255) begin : g_param_chk
    $error("leaf_stream_arbiter: illegal parameter combination");
  end

  logic [NUM_REQ-1:0][PAYLOAD_BITS-1:0] din_arr;
  logic [NUM_REQ-1:0]                   vld;
  assign din_arr = bus.din_req;
  assign vld     = bus.vld_req;

  logic                    out_valid;
  logic [PAYLOAD_BITS-1:0] out_data;
  logic [SRC_BITS-1:0]     out_src;
  logic [IW-1:0]           rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]           rr_sel, sel;
  logic                    rr_hit, sel_hit;
  logic                    can_load, load;
  logic [IW:0]             cand;
  logic [NUM_REQ-1:0]      ack_vec;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!rr_hit && vld[cand[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_sel = cand[IW-1:0];
      end
    end
  end

  assign can_load = !out_valid || bus.ack_out;

`ifdef ARB_BURST_LOCK_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        state, state_nxt;
  logic [IW-1:0] lock_id, lock_id_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;

  always_ff @(posedge clk_user) begin
    if (!reset) begin
      state    <= IDLE;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_id  <= lock_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_id_nxt  = lock_id;
    beat_cnt_nxt = beat_cnt;
    rr_ptr_nxt   = rr_ptr;
    sel          = rr_sel;
    sel_hit      = rr_hit;
    if (state == LOCKED) begin
      sel     = lock_id;
      sel_hit = vld[lock_id];
    end
    load = reset && can_load && sel_hit;
    case (state)
      IDLE: begin
        if (load) begin
          if (BURST_LEN == 1) begin
            rr_ptr_nxt = inc_ptr(sel);
          end else begin
            state_nxt    = LOCKED;
            lock_id_nxt  = sel;
            beat_cnt_nxt = CW'(1);
          end
        end
      end
      LOCKED: begin
        // Holder went idle while we could have taken a word: release early.
        if (can_load && !vld[lock_id]) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
          rr_ptr_nxt   = inc_ptr(lock_id);
        end else if (load) begin
          if (beat_cnt == CW'(BURST_LEN - 1)) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = inc_ptr(lock_id);
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  always_comb begin
    sel        = rr_sel;
    sel_hit    = rr_hit;
    load       = reset && can_load && sel_hit;
    rr_ptr_nxt = load ? inc_ptr(sel) : rr_ptr;
  end
`endif

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack_vec[i] = load && (sel == IW'(i));
  end

  // Single output register; drain and refill in one cycle keep the stream bubble-free.
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= din_arr[sel];
        out_src   <= SRC_BITS'(sel);
      end else if (bus.ack_out) begin
        out_valid <= 1'b0;
      end
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign bus.ack_req = ack_vec;
  assign bus.dout    = out_data;
  assign bus.vld_out = out_valid;
  assign bus.src_out = out_src;
endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Randomized bench for leaf_stream_arbiter: cycle model of the arbitration rules plus a
// per-source sequence scoreboard; honours ARB_BURST_LOCK_EN when defined.
module tb_leaf_stream_arbiter;
  localparam int N  = 4;
  localparam int PB = 32;
  localparam int SB = 4;
  localparam int BL = 4;
`ifdef ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk_user = 1'b0;
  logic reset;
  always #5 clk_user = ~clk_user;

  leaf_stream_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_REQ(N), .SRC_BITS(SB)) bus();

  leaf_stream_arbiter #(.PAYLOAD_BITS(PB), .NUM_REQ(N), .SRC_BITS(SB), .BURST_LEN(BL)) dut (
    .clk_user(clk_user),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_src   = 0;
  int          m_ptr   = 0;
  int          m_lock  = -1;
  int          m_beats = 0;
  int          in_seq [N];
  int          out_seq[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int i, input int s);
    return {8'(i), 24'(s)};
  endfunction

  function automatic int model_sel(input logic [N-1:0] v);
    if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model advances on every active edge.
  always @(posedge clk_user) begin
    int  s;
    bit  can, ld;
    if (!reset) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_lock = -1; m_beats = 0;
    end else begin
      can = !m_valid || bus.ack_out;
      s   = model_sel(bus.vld_req);
      ld  = can && (s >= 0);
      if (LOCK) begin
        if (m_lock >= 0) begin
          if (can && !bus.vld_req[m_lock]) begin
            m_ptr = (m_lock + 1) % N; m_lock = -1; m_beats = 0;
          end else if (ld) begin
            m_beats++;
            if (m_beats == BL) begin
              m_ptr = (m_lock + 1) % N; m_lock = -1; m_beats = 0;
            end
          end
        end else if (ld) begin
          if (BL == 1) m_ptr = (s + 1) % N;
          else begin m_lock = s; m_beats = 1; end
        end
      end else if (ld) begin
        m_ptr = (s + 1) % N;
      end
      if (ld) begin
        m_data = word(s, in_seq[s]);
        m_src  = s;
        m_valid = 1'b1;
        in_seq[s]++;
      end else if (bus.ack_out) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: runs mid-cycle when inputs and outputs are settled.
  always @(negedge clk_user) begin
    int          s;
    logic [N-1:0] exp_ack;
    int          os;
    s = model_sel(bus.vld_req);
    exp_ack = '0;
    if (reset && (!m_valid || bus.ack_out) && s >= 0) exp_ack[s] = 1'b1;
    check("ack_req", 32'(bus.ack_req), 32'(exp_ack));
    check("vld_out", 32'(bus.vld_out), 32'(m_valid));
    if (m_valid) begin
      check("dout", bus.dout, m_data);
      check("src_out", 32'(bus.src_out), 32'(m_src));
    end
    if (!reset) begin
      for (int i = 0; i < N; i++) out_seq[i] = in_seq[i];
    end else if (bus.vld_out === 1'b1 && bus.ack_out) begin
      os = int'(bus.src_out);
      if (os >= N) begin
        check("src_range", 32'(os), 32'(N - 1));
      end else begin
        check("order", bus.dout, word(os, out_seq[os]));
        out_seq[os]++;
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic a, input logic r);
    bus.vld_req = v;
    bus.ack_out = a;
    reset       = r;
    for (int i = 0; i < N; i++) bus.din_req[i*PB +: PB] = word(i, in_seq[i]);
    @(posedge clk_user);
    #1;
  endtask

  initial begin
    logic [31:0] hold;
    int          s0;
    bus.din_req = '0;

    // reset held with everybody requesting
    for (int k = 0; k < 3; k++) begin
      drive('1, 1'b1, 1'b0);
      check("rst_vld_out", 32'(bus.vld_out), 32'd0);
      check("rst_dout", bus.dout, 32'd0);
      check("rst_ack_req", 32'(bus.ack_req), 32'd0);
    end

    // all requesters continuously valid: round robin or burst pattern
    for (int k = 0; k < 16; k++) begin
      drive('1, 1'b1, 1'b1);
      check("rr_order", 32'(bus.src_out), LOCK ? 32'(k / BL) : 32'(k % N));
    end
    drive('0, 1'b1, 1'b1);
    drive('0, 1'b1, 1'b1);

    // single requester streaming, no bubbles
    s0 = in_seq[2];
    for (int k = 0; k < 8; k++) begin
      drive(4'b0100, 1'b1, 1'b1);
      check("single_vld", 32'(bus.vld_out), 32'd1);
      check("single_dout", bus.dout, word(2, s0 + k));
      check("single_src", 32'(bus.src_out), 32'd2);
    end

    // backpressure with register full
    hold = bus.dout;
    for (int k = 0; k < 5; k++) begin
      drive('1, 1'b0, 1'b1);
      check("bp_vld", 32'(bus.vld_out), 32'd1);
      check("bp_dout", bus.dout, hold);
      check("bp_ack_req", 32'(bus.ack_req), 32'd0);
    end
    drive('1, 1'b1, 1'b1);
    check("bp_reload_vld", 32'(bus.vld_out), 32'd1);
    check("bp_reload_src", 32'(bus.src_out), 32'd3);

    // reset while holding a word
    drive('1, 1'b0, 1'b1);
    check("mid_vld_before", 32'(bus.vld_out), 32'd1);
    drive('1, 1'b0, 1'b0);
    check("mid_rst_vld", 32'(bus.vld_out), 32'd0);
    drive('1, 1'b1, 1'b1);
    check("mid_restart_src", 32'(bus.src_out), 32'd0);

`ifdef ARB_BURST_LOCK_EN
    // lock on req 1, which goes idle after two beats while req 3 waits
    drive('0, 1'b1, 1'b0);
    drive(4'b1010, 1'b1, 1'b1);
    check("bub_src0", 32'(bus.src_out), 32'd1);
    drive(4'b1010, 1'b1, 1'b1);
    check("bub_src1", 32'(bus.src_out), 32'd1);
    drive(4'b1000, 1'b1, 1'b1);
    check("bub_gap", 32'(bus.vld_out), 32'd0);
    drive(4'b1000, 1'b1, 1'b1);
    check("bub_next_src", 32'(bus.src_out), 32'd3);
`endif

    // randomized traffic with occasional reset
    for (int k = 0; k < 3000; k++)
      drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));

    drive('0, 1'b1, 1'b1);
    drive('0, 1'b1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
